// File: rtl/adder_result_accumulator_pkg.sv
// adder_pkg: constants and types shared by the adder stage and its result accumulator
// No ports. Provides the default widths, the beat width rule and the accumulator FSM state type.
package adder_pkg;
    localparam int DATA_W_DEF = 4;
    localparam int ACC_W_DEF  = 12;
    localparam int BEAT_W     = DATA_W_DEF + 1;
    typedef enum logic {ACC, HOLD} acc_state_t;
    function automatic int beat_w(input int data_w);
        return data_w + 1;
    endfunction
endpackage

// File: rtl/adder_result_accumulator_if.sv
// adder_result_accumulator_if: beat input and frame result handshakes of the accumulator
// slave  (accumulator): takes in_valid/s_in/cout_in/clear/out_ready, drives in_ready/out_valid/out_sum/out_overflow/out_count
// master (upstream and consumer side): the mirror image
interface adder_result_accumulator_if #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 12,
    parameter int CNT_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] s_in;
    logic              cout_in;
    logic              clear;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_overflow;
    logic [CNT_W-1:0]  out_count;
    modport slave (input in_valid, s_in, cout_in, clear, out_ready,
                   output in_ready, out_valid, out_sum, out_overflow, out_count);
    modport master (output in_valid, s_in, cout_in, clear, out_ready,
                    input in_ready, out_valid, out_sum, out_overflow, out_count);
endinterface

// File: rtl/adder_result_accumulator_add_sat.sv
// acc_add_sat: adds one beat to the accumulator, wrapping or clamping on overflow
// i_acc: current total, i_beat: zero-extended beat, o_sum: new total, o_ovf: the add exceeded ACC_W bits
module acc_add_sat #(
    parameter int ACC_W    = 12,
    parameter int BEAT_W   = 5,
    parameter int SATURATE = 0
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [BEAT_W-1:0] i_beat,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_ovf
);
    logic [ACC_W:0] w_next;
    // both operands fit in ACC_W bits, so the extra top bit is exactly the overflow
    assign w_next = {1'b0, i_acc} + {{(ACC_W + 1 - BEAT_W){1'b0}}, i_beat};
    assign o_ovf  = w_next[ACC_W];
    assign o_sum  = (o_ovf && SATURATE != 0) ? '1 : w_next[ACC_W-1:0];
endmodule

// File: rtl/adder_result_accumulator.sv
// adder_result_accumulator: sums BEATS adder {Cout,S} beats per frame and hands the total downstream
// clk/rst_n: clock and async active-low reset; bus: slave side of the beat/result handshakes
// in_ready is high while accumulating, out_valid while holding a finished frame; clear aborts the frame
module adder_result_accumulator
    import adder_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter int BEATS    = 8,
    parameter int SATURATE = 0
) (
    input logic                        clk,
    input logic                        rst_n,
    adder_result_accumulator_if.slave  bus
);
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam int BW    = beat_w(DATA_W);
    acc_state_t       r_state, w_state_nxt;
    logic [ACC_W-1:0] r_acc, w_acc_nxt, w_sum;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic             r_ovf, w_ovf_nxt, w_add_ovf;
    acc_add_sat #(.ACC_W(ACC_W), .BEAT_W(BW), .SATURATE(SATURATE)) u_add (
        .i_acc  (r_acc),
        .i_beat ({bus.cout_in, bus.s_in}),
        .o_sum  (w_sum),
        .o_ovf  (w_add_ovf)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACC;
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end
    // clear outranks both the beat accept and the output handshake
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_count_nxt = r_count;
        w_ovf_nxt   = r_ovf;
        if (bus.clear || (r_state == HOLD && bus.out_ready)) begin
            w_state_nxt = ACC;
            w_acc_nxt   = '0;
            w_count_nxt = '0;
            w_ovf_nxt   = 1'b0;
        end else if (r_state == ACC && bus.in_valid) begin
            w_acc_nxt   = w_sum;
            w_count_nxt = r_count + CNT_W'(1);
            w_ovf_nxt   = r_ovf | w_add_ovf;
            w_state_nxt = (r_count == CNT_W'(BEATS - 1)) ? HOLD : ACC;
        end
    end
    assign bus.in_ready     = (r_state == ACC);
    assign bus.out_valid    = (r_state == HOLD);
    assign bus.out_sum      = r_acc;
    assign bus.out_overflow = r_ovf;
    assign bus.out_count    = r_count;
endmodule

// File: tb/tb_adder_result_accumulator.sv
// tb_adder_result_accumulator: self-checking bench for several accumulator configurations
module tb_adder_result_accumulator;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       in_valid = 1'b0, cout = 1'b0, clear = 1'b0, out_ready = 1'b0;
    logic [4:0] s = '0;
    int         errors = 0, checks = 0;

    always #5 clk = ~clk;

    adder_result_accumulator_if #(.DATA_W(4), .ACC_W(12), .CNT_W(4)) if0();
    adder_result_accumulator_if #(.DATA_W(4), .ACC_W(6),  .CNT_W(2)) if1();
    adder_result_accumulator_if #(.DATA_W(4), .ACC_W(6),  .CNT_W(2)) if2();
    adder_result_accumulator_if #(.DATA_W(5), .ACC_W(6),  .CNT_W(4)) if3();
    adder_result_accumulator_if #(.DATA_W(4), .ACC_W(12), .CNT_W(1)) if4();

    assign {if0.in_valid, if0.cout_in, if0.clear, if0.out_ready, if0.s_in} = {in_valid, cout, clear, out_ready, s[3:0]};
    assign {if1.in_valid, if1.cout_in, if1.clear, if1.out_ready, if1.s_in} = {in_valid, cout, clear, out_ready, s[3:0]};
    assign {if2.in_valid, if2.cout_in, if2.clear, if2.out_ready, if2.s_in} = {in_valid, cout, clear, out_ready, s[3:0]};
    assign {if3.in_valid, if3.cout_in, if3.clear, if3.out_ready, if3.s_in} = {in_valid, cout, clear, out_ready, s};
    assign {if4.in_valid, if4.cout_in, if4.clear, if4.out_ready, if4.s_in} = {in_valid, cout, clear, out_ready, s[3:0]};

    adder_result_accumulator #(.DATA_W(4), .ACC_W(12), .BEATS(8), .SATURATE(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    adder_result_accumulator #(.DATA_W(4), .ACC_W(6),  .BEATS(3), .SATURATE(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    adder_result_accumulator #(.DATA_W(4), .ACC_W(6),  .BEATS(3), .SATURATE(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    adder_result_accumulator #(.DATA_W(5), .ACC_W(6),  .BEATS(8), .SATURATE(0)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));
    adder_result_accumulator #(.DATA_W(4), .ACC_W(12), .BEATS(1), .SATURATE(1)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    task automatic do_reset();
        @(negedge clk);
        {in_valid, cout, clear, out_ready, s} = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic beat(input logic c, input logic [4:0] v);
        in_valid = 1'b1;
        cout     = c;
        s        = v;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", if0.out_valid); end
        checks++; if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", if0.in_ready); end
        checks++; if (if0.out_sum !== 12'd0) begin errors++; $display("FAIL reset_out_sum: got %0d want 0", if0.out_sum); end
        checks++; if (if0.out_count !== 4'd0) begin errors++; $display("FAIL reset_out_count: got %0d want 0", if0.out_count); end
        checks++; if (if0.out_overflow !== 1'b0) begin errors++; $display("FAIL reset_out_overflow: got %b want 0", if0.out_overflow); end
    endtask

    task automatic test_basic();
        do_reset();
        repeat (7) beat(1'b1, 5'd8);
        checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", if0.out_valid); end
        beat(1'b1, 5'd8);
        checks++; if (if0.out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %b want 1", if0.out_valid); end
        checks++; if (if0.in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready: got %b want 0", if0.in_ready); end
        checks++; if (if0.out_sum !== 12'd192) begin errors++; $display("FAIL basic_out_sum: got %0d want 192", if0.out_sum); end
        checks++; if (if0.out_count !== 4'd8) begin errors++; $display("FAIL basic_out_count: got %0d want 8", if0.out_count); end
        checks++; if (if0.out_overflow !== 1'b0) begin errors++; $display("FAIL basic_out_overflow: got %b want 0", if0.out_overflow); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (if0.in_ready !== 1'b1 || if0.out_valid !== 1'b0) begin errors++; $display("FAIL basic_after_hs: got in_ready=%b out_valid=%b want 1/0", if0.in_ready, if0.out_valid); end
        checks++; if (if0.out_sum !== 12'd0) begin errors++; $display("FAIL basic_acc_cleared: got %0d want 0", if0.out_sum); end
    endtask

    task automatic test_overflow();
        do_reset();
        repeat (3) beat(1'b1, 5'd15);
        checks++; if (if1.out_valid !== 1'b1) begin errors++; $display("FAIL ovf_wrap_valid: got %b want 1", if1.out_valid); end
        checks++; if (if1.out_sum !== 6'd29) begin errors++; $display("FAIL ovf_wrap_sum: got %0d want 29", if1.out_sum); end
        checks++; if (if1.out_overflow !== 1'b1) begin errors++; $display("FAIL ovf_wrap_flag: got %b want 1", if1.out_overflow); end
        checks++; if (if2.out_sum !== 6'd63) begin errors++; $display("FAIL ovf_sat_sum: got %0d want 63", if2.out_sum); end
        checks++; if (if2.out_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sat_flag: got %b want 1", if2.out_overflow); end
    endtask

    task automatic test_backpressure();
        int         exp_sum;
        logic [4:0] v;
        exp_sum = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            v = 5'($urandom_range(0, 31));
            beat(v[4], {1'b0, v[3:0]});
            exp_sum += int'(v);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            s        = 5'($urandom_range(0, 15));
            @(negedge clk);
            checks++; if (if0.in_ready !== 1'b0 || if0.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_%0d: got in_ready=%b out_valid=%b want 0/1", i, if0.in_ready, if0.out_valid); end
            checks++; if (if0.out_sum !== 12'(exp_sum) || if0.out_count !== 4'd8) begin errors++; $display("FAIL bp_stable_%0d: got sum=%0d count=%0d want %0d/8", i, if0.out_sum, if0.out_count, exp_sum); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (if0.in_ready !== 1'b1 || if0.out_sum !== 12'd0 || if0.out_count !== 4'd0) begin errors++; $display("FAIL bp_release: got in_ready=%b sum=%0d count=%0d want 1/0/0", if0.in_ready, if0.out_sum, if0.out_count); end
        repeat (8) beat(1'b0, 5'd1);
        checks++; if (if0.out_sum !== 12'd8 || if0.out_count !== 4'd8) begin errors++; $display("FAIL bp_next_frame: got sum=%0d count=%0d want 8/8", if0.out_sum, if0.out_count); end
    endtask

    task automatic test_clear();
        do_reset();
        repeat (4) beat(1'b0, 5'd5);
        in_valid = 1'b1;
        s        = 5'd5;
        clear    = 1'b1;
        @(negedge clk);
        {in_valid, clear} = 2'b00;
        checks++; if (if0.out_sum !== 12'd0 || if0.out_count !== 4'd0) begin errors++; $display("FAIL clear_drop: got sum=%0d count=%0d want 0/0", if0.out_sum, if0.out_count); end
        repeat (8) beat(1'b0, 5'd1);
        checks++; if (if0.out_valid !== 1'b1 || if0.out_sum !== 12'd8 || if0.out_count !== 4'd8) begin errors++; $display("FAIL clear_refill: got valid=%b sum=%0d count=%0d want 1/8/8", if0.out_valid, if0.out_sum, if0.out_count); end
        clear     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        {clear, out_ready} = 2'b00;
        checks++; if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1 || if0.out_sum !== 12'd0) begin errors++; $display("FAIL clear_in_hold: got valid=%b in_ready=%b sum=%0d want 0/1/0", if0.out_valid, if0.in_ready, if0.out_sum); end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (8) beat(1'b1, 5'd3);
        checks++; if (if0.out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_hold: got %b want 1", if0.out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1) begin errors++; $display("FAIL areset_handshake: got valid=%b in_ready=%b want 0/1", if0.out_valid, if0.in_ready); end
        checks++; if (if0.out_sum !== 12'd0 || if0.out_count !== 4'd0 || if0.out_overflow !== 1'b0) begin errors++; $display("FAIL areset_outputs: got sum=%0d count=%0d ovf=%b want 0/0/0", if0.out_sum, if0.out_count, if0.out_overflow); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ovf_beat2();
        do_reset();
        repeat (2) beat(1'b1, 5'd8);
        repeat (6) beat(1'b0, 5'd0);
        checks++; if (if3.out_valid !== 1'b1 || if3.out_count !== 4'd8) begin errors++; $display("FAIL ovf2_frame: got valid=%b count=%0d want 1/8", if3.out_valid, if3.out_count); end
        checks++; if (if3.out_overflow !== 1'b1) begin errors++; $display("FAIL ovf2_sticky: got %b want 1", if3.out_overflow); end
        checks++; if (if3.out_sum !== 6'd16) begin errors++; $display("FAIL ovf2_sum: got %0d want 16", if3.out_sum); end
    endtask

    task automatic test_beats1();
        do_reset();
        out_ready = 1'b1;
        beat(1'b1, 5'd4);
        checks++; if (if4.out_valid !== 1'b1 || if4.out_sum !== 12'd20 || if4.out_count !== 1'd1) begin errors++; $display("FAIL beats1_frame: got valid=%b sum=%0d count=%0d want 1/20/1", if4.out_valid, if4.out_sum, if4.out_count); end
        in_valid = 1'b1;
        s        = 5'd7;
        @(negedge clk);
        {in_valid, out_ready} = 2'b00;
        checks++; if (if4.out_valid !== 1'b0 || if4.out_sum !== 12'd0 || if4.out_count !== 1'd0) begin errors++; $display("FAIL beats1_no_bypass: got valid=%b sum=%0d count=%0d want 0/0/0", if4.out_valid, if4.out_sum, if4.out_count); end
    endtask

    task automatic test_random();
        int         total;
        logic [4:0] v;
        do_reset();
        for (int f = 0; f < 25; f++) begin
            total = 0;
            for (int b = 0; b < 3; b++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                checks++; if (if1.in_ready !== 1'b1) begin errors++; $display("FAIL rand_in_ready f%0d b%0d: got %b want 1", f, b, if1.in_ready); end
                v = 5'($urandom_range(0, 31));
                beat(v[4], {1'b0, v[3:0]});
                total += int'(v);
            end
            checks++; if (if1.out_valid !== 1'b1 || if1.out_count !== 2'd3) begin errors++; $display("FAIL rand_frame f%0d: got valid=%b count=%0d want 1/3", f, if1.out_valid, if1.out_count); end
            checks++; if (if1.out_sum !== 6'(total % 64) || if1.out_overflow !== (total > 63)) begin errors++; $display("FAIL rand_wrap f%0d: got sum=%0d ovf=%b want %0d/%b", f, if1.out_sum, if1.out_overflow, total % 64, total > 63); end
            checks++; if (if2.out_sum !== 6'(total > 63 ? 63 : total) || if2.out_overflow !== (total > 63)) begin errors++; $display("FAIL rand_sat f%0d: got sum=%0d ovf=%b want %0d/%b", f, if2.out_sum, if2.out_overflow, total > 63 ? 63 : total, total > 63); end
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                checks++; if (if1.out_valid !== 1'b1 || if1.out_sum !== 6'(total % 64)) begin errors++; $display("FAIL rand_stall f%0d: got valid=%b sum=%0d want 1/%0d", f, if1.out_valid, if1.out_sum, total % 64); end
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_clear();
        test_async_reset();
        test_ovf_beat2();
        test_beats1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/adder_result_accumulator.md
Name: adder_result_accumulator

Overview:
- Downstream consumer of the 4-bit CLA adder stage. Each accepted beat is the adder's {Cout, S} pair, read as an unsigned 5-bit value.
- Sums a fixed number of beats into a wide accumulator, then presents the frame total, overflow flag and beat count on a valid/ready output.
- Feeds the results and checker logic that sits after the adder.

Parameters:
- DATA_W, 4: width of adder sum S; beat width is DATA_W+1.
- ACC_W, 12: accumulator/result width; must be >= DATA_W+1.
- BEATS, 8: beats per frame, >= 1.
- SATURATE, 0: on overflow, 0 = wrap modulo 2^ACC_W, 1 = clamp to all-ones.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  beat present on s_in/cout_in.
- in_ready  out  1  block can accept a beat this cycle.
- s_in  in  DATA_W  adder sum S.
- cout_in  in  1  adder carry-out Cout.
- clear  in  1  synchronous frame abort.
- out_valid  out  1  frame result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  ACC_W  frame total.
- out_overflow  out  1  sticky overflow for the frame.
- out_count  out  clog2(BEATS+1)  beats accumulated in the frame.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=ACC, acc=0, count=0, ovf=0.
  - out_valid=0, in_ready=1, out_sum=0, out_overflow=0, out_count=0.
- Beat value: beat = {cout_in, s_in}, zero-extended to ACC_W+1 bits for the add.
- A beat is accepted when in_valid && in_ready on a clock edge.
- State ACC:
  - in_ready=1, out_valid=0.
  - On accept: next = acc + beat, count += 1.
  - If next > 2^ACC_W-1: ovf<=1; acc <= all-ones if SATURATE=1, else next[ACC_W-1:0].
  - If the accepted beat is beat number BEATS, go to HOLD.
- State HOLD:
  - in_ready=0, out_valid=1.
  - out_sum/out_overflow/out_count driven from registers and stable until the handshake completes.
  - On out_valid && out_ready: acc=0, count=0, ovf=0, go to ACC.
  - No bypass: a new frame's first beat is accepted no earlier than the cycle after the output handshake.
- Latency: out_valid rises on the edge after the last beat is accepted (1 cycle).
- Throughput: one frame per BEATS+1 cycles at best.
- Outputs are always registered; no combinational path from in_* to out_*.
- clear:
  - Highest priority in either state.
  - Sets acc=0, count=0, ovf=0, state=ACC.
  - A beat presented in the same cycle is dropped; an output handshake in the same cycle is discarded.
- Overflow flag:
  - Sticky within a frame: once set it stays set even if later beats do not overflow.
  - Overflow on the final beat is reflected in out_overflow.
- Back-pressure: out_ready held low keeps HOLD indefinitely with outputs unchanged; in_ready stays 0.
- in_valid while in_ready=0: ignored; the upstream stage must hold the beat.
- BEATS=1: every accepted beat produces a frame.
- Reset mid-frame or mid-HOLD: immediate return to reset values; the partial frame is lost.

Decomposition:
- Shared package (adder_pkg):
  - state enum {ACC, HOLD}.
  - BEAT_W = DATA_W+1 constant.
  - Default DATA_W/ACC_W constants shared with the adder stage.
- One natural sub-module, acc_add_sat: combinational ACC_W-bit accumulate with wrap/saturate select and overflow flag output. The FSM, registers and handshake stay in the top module.

Test Plan:
- Defaults; 8 beats of s_in=4'b1000, cout_in=1 (the adder output for A=4'b1111, B=4'b1001), one per cycle -> out_valid 1 cycle after the 8th beat; out_sum=192, out_count=8, out_overflow=0.
- ACC_W=6, SATURATE=0; beats 31,31,31 with BEATS=3 -> out_sum=93 mod 64=29, out_overflow=1. Same stimulus with SATURATE=1 -> out_sum=63, out_overflow=1.
- out_ready=0 for 5 cycles in HOLD -> outputs stable, in_ready=0, extra in_valid beats not consumed. Then out_ready=1 -> next cycle in_ready=1, acc=0.
- clear asserted after 4 beats (value 5 each) together with in_valid -> that beat dropped. The next 8 beats of 1 -> out_sum=8, out_count=8.
- rst_n pulsed low mid-HOLD, asynchronously between edges -> out_valid=0 and all outputs 0 immediately, in_ready=1.
- Overflow on beat 2 only (ACC_W=6, beats 40,40,0,0,0,0,0,0, SATURATE=0) -> out_overflow=1 at frame end, out_sum=16.
